ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Pipeline register between the LEGv8 ALU and the data-memory stage. It captures the ALU result `F` and 4-bit `status` together with the instruction's control fields. It holds the architectural NZCV flag register and resolves CBZ/CBNZ/B.cond branch decisions. It also decouples the ALU from memory back-pressure through a two-entry skid buffer with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 64, datapath width of the result and store data.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept; registered.
- `alu_F`  in  WIDTH  ALU result.
- `alu_status`  in  4  ALU status `{V,C,N,Z}` (bit3..bit0).
- `set_flags`  in  1  instruction writes NZCV (ADDS/SUBS/ANDS).
- `branch_op`  in  2  00 none, 01 CBZ, 10 CBNZ, 11 B.cond.
- `cond`  in  4  LEGv8 condition code for B.cond.
- `store_data`  in  WIDTH  register value for STUR.
- `dest_reg`  in  5  writeback register.
- `reg_write`, `mem_read`, `mem_write`  in  1 each  control bits.
- `flush`  in  1  kill all held and incoming entries.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts head.
- `out_F`, `out_store_data`  out  WIDTH  head entry data.
- `out_dest_reg`  out  5; `out_reg_write`, `out_mem_read`, `out_mem_write`  out  1 each  head entry control.
- `out_branch_taken`  out  1  head entry's resolved branch decision.
- `flags`  out  4  architectural `{V,C,N,Z}`.

## Operation
- Storage: a head register (drives the `out_*` ports) and one skid register.
- Accept: `acc = in_valid & in_ready & ~flush`.
- Pop: `pop = out_valid & out_ready`.
- Routing:
  - If head is empty, or head pops this cycle while skid is empty, the accepted entry goes to head.
  - Otherwise the accepted entry goes to skid.
  - On pop with skid full, skid moves to head. In that cycle a new accept targets skid.
- `in_ready` is registered and equals `~skid_valid_next`. It is never combinationally dependent on `out_ready`.
- Flags update only on `acc & set_flags`: `flags <= alu_status`. Program order is preserved because acceptance is in order.
- Branch resolution happens at accept time and is stored with the entry:
  - CBZ: taken = `alu_status[0]`.
  - CBNZ: taken = `~alu_status[0]`.
  - B.cond: evaluated against the pre-update `flags`.
  - none: 0.
- Condition codes for B.cond:
  - EQ 0000 Z; NE 0001 !Z.
  - HS 0010 C; LO 0011 !C.
  - MI 0100 N; PL 0101 !N.
  - VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !(C&!Z).
  - GE 1010 N==V; LT 1011 N!=V.
  - GT 1100 !Z&(N==V); LE 1101 !(!Z&(N==V)).
  - AL 1110 and NV 1111: 1.
- Flush: both valid bits clear next edge and the incoming entry is dropped. A flushed entry never updates `flags`. Flags already committed are retained.
- Data registers need no reset. Only valid bits, `flags` and `in_ready` reset.

## Timing
- Reset: `out_valid=0`, skid empty, `in_ready=1`, `flags=4'b0000`, `out_branch_taken=0`. All control outputs are 0. Data outputs are don't-care.
- Latency: an entry accepted at edge N appears on `out_*` after edge N when head was empty. Flags written at edge N are visible on `flags` after edge N.
- Back-to-back flag ops: a B.cond accepted the cycle after an ADDS sees the ADDS flags.
- Full (head and skid valid, `out_ready=0`): `in_ready=0`. Holding `in_valid` high causes no state change.
- Simultaneous `flush` and `pop`: the pop completes downstream, and both entries are then empty.
- Async reset mid-stream clears everything immediately, independent of the clock.

## Test plan
- Reset with `in_valid=1`, release -> `out_valid=0`, `flags=0000`, `in_ready=1` before the first edge; the first entry appears one cycle after release.
- ADDS with `alu_status=4'b0001`, then B.cond EQ -> `flags=0001`, B.cond `out_branch_taken=1`. The same pair with NE -> 0.
- `out_ready=0` for 3 cycles while streaming F=1,2,3 -> head=1, skid=2, `in_ready=0`, 3 held. Then `out_ready=1` -> outputs 1,2,3 in order with no loss or duplication.
- CBZ with Z=1 -> taken=1. CBNZ with Z=1 -> taken=0. Branch op none -> 0.
- SUBS (status 1010) accepted together with `flush=1` -> entry dropped, `flags` unchanged, `out_valid=0`.
- Randomized valid/ready with a scoreboard for 10k cycles -> order preserved, flags match a reference model, `in_ready` never combinational on `out_ready`.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage for the LEGv8 datapath. It captures the ALU result and
// control fields, keeps the architectural NZCV register and resolves branches
// at accept time. A head register plus one skid register decouple the ALU from
// memory back-pressure while keeping in_ready a pure register output.
module ex_mem_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_F,
  input  logic [3:0]       alu_status,
  input  logic             set_flags,
  input  logic [1:0]       branch_op,
  input  logic [3:0]       cond,
  input  logic [WIDTH-1:0] store_data,
  input  logic [4:0]       dest_reg,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_F,
  output logic [WIDTH-1:0] out_store_data,
  output logic [4:0]       out_dest_reg,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_branch_taken,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_CBZ  = 2'b01,
    BR_CBNZ = 2'b10,
    BR_COND = 2'b11
  } br_op_e;

  typedef struct packed {
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] store_data;
    logic [4:0]       dest_reg;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch_taken;
  } entry_t;

  // Evaluate a B.cond code against {V,C,N,Z}. Odd codes invert the even base
  // condition, except AL/NV which are always true.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] nzcv);
    logic v, cf, n, z, base;
    {v, cf, n, z} = nzcv;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] != 3'd7) ? (base ^ c[0]) : 1'b1;
  endfunction

  logic   head_valid_q, head_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q;
  logic   in_ready_d;
  logic [3:0] flags_q;
  entry_t head_q, skid_q;
  entry_t new_entry;
  logic   acc, pop;
  logic   load_head_new, load_head_skid, load_skid;
  logic   taken;

  assign acc = in_valid & in_ready_q & ~flush;
  assign pop = head_valid_q & out_ready;

  // Resolve the incoming branch against the flags as they stand before this accept.
  always_comb begin
    taken = 1'b0;
    case (br_op_e'(branch_op))
      BR_CBZ:  taken = alu_status[0];
      BR_CBNZ: taken = ~alu_status[0];
      BR_COND: taken = cond_holds(cond, flags_q);
      default: taken = 1'b0;
    endcase
  end

  assign new_entry = '{f: alu_F, store_data: store_data, dest_reg: dest_reg,
                       reg_write: reg_write, mem_read: mem_read,
                       mem_write: mem_write, branch_taken: taken};

  // Routing between head and skid; the head is always filled before the skid.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    head_valid_d   = head_valid_q;
    skid_valid_d   = skid_valid_q;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop && skid_valid_q) begin
      load_head_skid = 1'b1;
      head_valid_d   = 1'b1;
      load_skid      = acc;
      skid_valid_d   = acc;
    end else if (!head_valid_q || pop) begin
      load_head_new = acc;
      head_valid_d  = acc;
    end else if (acc) begin
      load_skid    = 1'b1;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  // Valid bits, registered in_ready and the architectural flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      flags_q      <= 4'b0000;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, as the flip-flops do.
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      if (acc && set_flags) flags_q <= alu_status;
    end
  end

  // Entry payload registers.
  // NOTE: payload carries no reset; the valid bits alone decide whether it means anything.
  always_ff @(posedge clock) begin
    if (load_head_skid)     head_q <= skid_q;
    else if (load_head_new) head_q <= new_entry;
    if (load_skid)          skid_q <= new_entry;
  end

  assign in_ready         = in_ready_q;
  assign flags            = flags_q;
  assign out_valid        = head_valid_q;
  assign out_F            = head_q.f;
  assign out_store_data   = head_q.store_data;
  assign out_dest_reg     = head_q.dest_reg;
  assign out_reg_write    = head_valid_q & head_q.reg_write;
  assign out_mem_read     = head_valid_q & head_q.mem_read;
  assign out_mem_write    = head_valid_q & head_q.mem_write;
  assign out_branch_taken = head_valid_q & head_q.branch_taken;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: stimulus pushes expected entries into a scoreboard,
// a negedge monitor pops and compares each entry the DUT hands downstream.
module tb_ex_mem_stage;
  localparam int W = 64;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid, in_ready, set_flags, reg_write, mem_read, mem_write;
  logic         flush, out_valid, out_ready;
  logic [W-1:0] alu_F, store_data, out_F, out_store_data;
  logic [3:0]   alu_status, cond, flags;
  logic [1:0]   branch_op;
  logic [4:0]   dest_reg, out_dest_reg;
  logic         out_reg_write, out_mem_read, out_mem_write, out_branch_taken;

  always #5 clock = ~clock;

  ex_mem_stage #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_F(alu_F), .alu_status(alu_status), .set_flags(set_flags),
    .branch_op(branch_op), .cond(cond), .store_data(store_data),
    .dest_reg(dest_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_F(out_F), .out_store_data(out_store_data),
    .out_dest_reg(out_dest_reg), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch_taken(out_branch_taken), .flags(flags)
  );

  typedef struct packed {
    logic [W-1:0] f;
    logic [W-1:0] sd;
    logic [4:0]   dest;
    logic         rw, mr, mw, tk;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] flags_m = 4'b0000;

  task automatic check(input string name, input logic [136:0] act, input logic [136:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference table of LEGv8 condition codes over {V,C,N,Z}.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic v, cf, n, z;
    {v, cf, n, z} = f;
    case (c)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return cf;
      4'b0011: return !cf;
      4'b0100: return n;
      4'b0101: return !n;
      4'b0110: return v;
      4'b0111: return !v;
      4'b1000: return cf && !z;
      4'b1001: return !(cf && !z);
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return !z && (n == v);
      4'b1101: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  // Monitor: compare every entry that leaves the stage.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got F=%h expected no entry", out_F);
      end else begin
        e = sb_q.pop_front();
        check("head_entry", {out_F, out_store_data, out_dest_reg, out_reg_write,
                             out_mem_read, out_mem_write, out_branch_taken}, e);
      end
    end
  end

  task automatic drive(input logic [W-1:0] f, input logic sf, input logic [1:0] bop,
                       input logic [3:0] cnd, input logic [3:0] st);
    alu_F = f; store_data = ~f; dest_reg = f[4:0];
    reg_write = 1'b1; mem_read = f[0]; mem_write = f[1];
    set_flags = sf; branch_op = bop; cond = cnd; alu_status = st;
  endtask

  function automatic exp_t mk(input logic [W-1:0] f, input logic tk);
    return '{f: f, sd: ~f, dest: f[4:0], rw: 1'b1, mr: f[0], mw: f[1], tk: tk};
  endfunction

  // Present one entry and hold it until accepted (bounded); in_valid stays high on return.
  task automatic send(input logic [W-1:0] f, input logic sf, input logic [1:0] bop,
                      input logic [3:0] cnd, input logic [3:0] st, input logic tk);
    drive(f, sf, bop, cnd, st);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        sb_q.push_back(mk(f, tk));
        if (sf) flags_m = st;
        @(posedge clock); #1;
        return;
      end
      @(posedge clock); #1;
    end
    checks++;
    failures++;
    $display("FAIL accept_timeout: got in_ready=0 for 20 cycles expected acceptance of F=%h", f);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0; set_flags = 1'b0; flush = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    logic rdy_before;
    logic [W-1:0] rf;
    logic [1:0]   rb;
    logic [3:0]   rc, rs;
    logic         rsf, tk;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    drive(64'h55, 1'b0, 2'b00, 4'h0, 4'h0);

    // Reset with in_valid high, then release between edges.
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_flags", flags, 4'b0000);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_branch_taken", out_branch_taken, 1'b0);
    send(64'h55, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    check("first_entry_valid", out_valid, 1'b1);
    check("first_entry_F", out_F, 64'h55);
    idle_cycles(2);

    // ADDS Z=1 then B.cond EQ back-to-back.
    send(64'h10, 1'b1, 2'b00, 4'h0, 4'b0001, 1'b0);
    check("adds_flags", flags, 4'b0001);
    send(64'h11, 1'b0, 2'b11, 4'b0000, 4'b0000, 1'b1);
    // Same pair with NE.
    send(64'h12, 1'b1, 2'b00, 4'h0, 4'b0001, 1'b0);
    send(64'h13, 1'b0, 2'b11, 4'b0001, 4'b0000, 1'b0);
    // V=1, N=0: GE false, LT true; C=1, Z=0: HI true, LS false.
    send(64'h14, 1'b1, 2'b00, 4'h0, 4'b1000, 1'b0);
    send(64'h15, 1'b0, 2'b11, 4'b1010, 4'b0000, 1'b0);
    send(64'h16, 1'b0, 2'b11, 4'b1011, 4'b0000, 1'b1);
    send(64'h17, 1'b1, 2'b00, 4'h0, 4'b0100, 1'b0);
    send(64'h18, 1'b0, 2'b11, 4'b1000, 4'b0000, 1'b1);
    send(64'h19, 1'b0, 2'b11, 4'b1001, 4'b0000, 1'b0);
    send(64'h1a, 1'b0, 2'b11, 4'b1111, 4'b0000, 1'b1);
    // CBZ / CBNZ with Z=1, and no branch.
    send(64'h20, 1'b0, 2'b01, 4'h0, 4'b0001, 1'b1);
    send(64'h21, 1'b0, 2'b10, 4'h0, 4'b0001, 1'b0);
    send(64'h22, 1'b0, 2'b00, 4'h0, 4'b0001, 1'b0);
    check("flags_after_branches", flags, 4'b0100);
    idle_cycles(3);

    // Back-pressure: head=1, skid=2, entry 3 held.
    out_ready = 1'b0;
    send(64'd1, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    send(64'd2, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    drive(64'd3, 1'b0, 2'b00, 4'h0, 4'h0);
    check("full_in_ready", in_ready, 1'b0);
    check("full_head", out_F, 64'd1);
    repeat (2) begin @(posedge clock); #1; end
    check("held_in_ready", in_ready, 1'b0);
    check("held_head", out_F, 64'd1);
    check("held_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    send(64'd3, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    idle_cycles(4);
    check("drain_bp", sb_q.size(), 0);

    // Flush with both entries full while popping: head leaves, skid is killed.
    out_ready = 1'b0;
    send(64'h30, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    send(64'h31, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    out_ready = 1'b1;
    flush = 1'b1;
    drive(64'h32, 1'b1, 2'b00, 4'h0, 4'b1010);
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    check("flush_pop_out_valid", out_valid, 1'b0);
    check("flush_pop_in_ready", in_ready, 1'b1);
    // SUBS accepted alongside flush on an empty stage: dropped, flags retained.
    in_valid = 1'b1; flush = 1'b1;
    drive(64'h33, 1'b1, 2'b00, 4'h0, 4'b1010);
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_flags", flags, 4'b0100);
    idle_cycles(2);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    send(64'h40, 1'b1, 2'b00, 4'h0, 4'b1111, 1'b0);
    send(64'h41, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b1);
    check("async_rst_flags", flags, 4'b0000);
    sb_q.delete();
    flags_m = 4'b0000;
    #1 reset_n = 1'b1;

    // Randomized valid/ready/flush against the scoreboard and flag model.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge clock); #1;
      if (flush) sb_q.delete();
      check("rnd_in_ready", in_ready, sb_q.size() < 2);
      check("rnd_out_valid", out_valid, sb_q.size() > 0);
      check("rnd_flags", flags, flags_m);
      rdy_before = in_ready;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_in_ready_indep", in_ready, rdy_before);
      rf = {$urandom(), $urandom()};
      rb = 2'($urandom_range(0, 3));
      rc = 4'($urandom_range(0, 15));
      rs = 4'($urandom_range(0, 15));
      rsf = 1'($urandom_range(0, 1));
      drive(rf, rsf, rb, rc, rs);
      flush = ($urandom_range(0, 63) == 0);
      in_valid = 1'($urandom_range(0, 1));
      if (in_valid && in_ready && !flush) begin
        case (rb)
          2'b01:   tk = rs[0];
          2'b10:   tk = !rs[0];
          2'b11:   tk = cond_model(rc, flags_m);
          default: tk = 1'b0;
        endcase
        sb_q.push_back(mk(rf, tk));
        if (rsf) flags_m = rs;
      end
    end
    @(posedge clock); #1;
    if (flush) sb_q.delete();
    idle_cycles(0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(posedge clock); #1;
    end
    check("final_drain", sb_q.size(), 0);
    check("final_flags", flags, flags_m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
